// File: rtl/laser_echo_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : laser_echo_emulator_if
// Description : Link bundle between the laser distance measurer and the echo
//               emulator (distance setting, laser strobe, sensor pulse and
//               status outputs).
// Revision    : 1.0  initial release
// ============================================================================
interface laser_echo_emulator_if #(
    parameter int DIST_W = 12,
    parameter int CNT_W  = 16
);
    logic [DIST_W-1:0] dist_set;
    logic              L;
    logic              S;
    logic              busy;
    logic [CNT_W-1:0]  echo_cnt;
    logic              miss;

    // Measurer / bench side: sets the distance, fires the laser.
    modport master (
        output dist_set,
        output L,
        input  S,
        input  busy,
        input  echo_cnt,
        input  miss
    );

    // Emulator side: answers with the reflected pulse.
    modport slave (
        input  dist_set,
        input  L,
        output S,
        output busy,
        output echo_cnt,
        output miss
    );
endinterface
`default_nettype wire

// File: rtl/laser_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : laser_echo_emulator
// Description : Target-side model of the laser distance link. Answers each
//               accepted rise of the laser strobe L with a sensor pulse S
//               after a round trip of 2*dist_set distance ticks.
//               Optional macro ECHO_JITTER_EN adds +/-1 tick range noise
//               from an 8-bit LFSR.
// Revision    : 1.0  initial release
// ============================================================================
module laser_echo_emulator #(
    parameter int DIST_W   = 12,
    parameter int TICK_DIV = 1,
    parameter int ECHO_LEN = 1,
    parameter int CNT_W    = 16
) (
    input  wire                  sys_clk,
    input  wire                  reset,
    laser_echo_emulator_if.slave bus
);

    localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_len_w = (ECHO_LEN > 1) ? $clog2(ECHO_LEN) : 1;
    localparam int c_dly_w = DIST_W + 1;

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_len_w-1:0] c_len_last = c_len_w'(ECHO_LEN - 1);
    // The rise cycle itself is tick phase 0, so the prescaler resumes at
    // phase 1 (wrapping to 0 when every cycle is a tick). With one tick per
    // cycle the rise cycle already counts as the first tick of the delay.
    localparam logic [c_pre_w-1:0] c_pre_after_rise = c_pre_w'((TICK_DIV == 1) ? 0 : 1);
    localparam bit                 c_rise_is_tick   = (TICK_DIV == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ECHO    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_l_d;
    logic [c_pre_w-1:0] r_presc;
    logic [c_pre_w-1:0] w_presc_nxt;
    logic [c_dly_w-1:0] r_dly;
    logic [c_dly_w-1:0] w_dly_nxt;
    logic [c_len_w-1:0] r_len;
    logic [c_len_w-1:0] w_len_nxt;
    logic               r_s;
    logic               w_s_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_miss;
    logic               w_miss_nxt;
    logic [CNT_W-1:0]   r_echo_cnt;
    logic [CNT_W-1:0]   w_echo_cnt_nxt;

    logic               w_rise;
    logic               w_tick;
    logic [c_dly_w-1:0] w_dly_base;
    logic [c_dly_w-1:0] w_dly_total;
    logic [c_dly_w-1:0] w_dly_load;

    assign w_rise     = bus.L & ~r_l_d;
    assign w_tick     = (TICK_DIV == 1) ? 1'b1 : (r_presc == c_pre_last);
    assign w_dly_base = {bus.dist_set, 1'b0};

`ifdef ECHO_JITTER_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Free-running range-noise source, advances every cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Offset -1/0/0/+1 tick; never shorten the round trip below 2 ticks.
    always_comb begin
        w_dly_total = w_dly_base;
        case (r_lfsr[1:0])
            2'b00: begin
                if (w_dly_base > c_dly_w'(2)) begin
                    w_dly_total = w_dly_base - c_dly_w'(1);
                end
            end
            2'b11:   w_dly_total = w_dly_base + c_dly_w'(1);
            default: w_dly_total = w_dly_base;
        endcase
    end
`else
    assign w_dly_total = w_dly_base;
`endif

    assign w_dly_load = c_rise_is_tick ? (w_dly_total - c_dly_w'(1)) : w_dly_total;

    // Next-state and next-output decode for the echo sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = w_tick ? '0 : (r_presc + c_pre_w'(1));
        w_dly_nxt      = r_dly;
        w_len_nxt      = r_len;
        w_s_nxt        = r_s;
        w_busy_nxt     = r_busy;
        w_miss_nxt     = 1'b0;
        w_echo_cnt_nxt = r_echo_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (bus.dist_set != '0) begin
                        w_state_nxt = ST_WAIT;
                        w_dly_nxt   = w_dly_load;
                        w_presc_nxt = c_pre_after_rise;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_miss_nxt  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_tick) begin
                    if (r_dly == c_dly_w'(1)) begin
                        w_state_nxt = ST_ECHO;
                        w_dly_nxt   = '0;
                        w_len_nxt   = '0;
                        w_s_nxt     = 1'b1;
                    end else begin
                        w_dly_nxt   = r_dly - c_dly_w'(1);
                    end
                end
            end
            ST_ECHO: begin
                if (w_tick) begin
                    if (r_len == c_len_last) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_s_nxt        = 1'b0;
                        w_echo_cnt_nxt = r_echo_cnt + CNT_W'(1);
                    end else begin
                        w_len_nxt      = r_len + c_len_w'(1);
                    end
                end
            end
            ST_HOLDOFF: begin
                // Re-arm only once the strobe is released.
                if (!bus.L) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops S at once.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_l_d      <= 1'b0;
            r_presc    <= '0;
            r_dly      <= '0;
            r_len      <= '0;
            r_s        <= 1'b0;
            r_busy     <= 1'b0;
            r_miss     <= 1'b0;
            r_echo_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_l_d      <= bus.L;
            r_presc    <= w_presc_nxt;
            r_dly      <= w_dly_nxt;
            r_len      <= w_len_nxt;
            r_s        <= w_s_nxt;
            r_busy     <= w_busy_nxt;
            r_miss     <= w_miss_nxt;
            r_echo_cnt <= w_echo_cnt_nxt;
        end
    end

    assign bus.S        = r_s;
    assign bus.busy     = r_busy;
    assign bus.miss     = r_miss;
    assign bus.echo_cnt = r_echo_cnt;

endmodule
`default_nettype wire

// File: doc/laser_echo_emulator.md
Name: laser_echo_emulator

Overview:
- Target-side model of the laser distance link: watches laser-fire strobe L and answers with sensor pulse S after a round-trip delay set by a programmable distance.
- Lets the laser distance measurer be exercised on the FPGA board and in simulation without optics; sits beside the measurer, with its S output driving the measurer's S input.
- Delay is counted in distance ticks from an internal prescaler.
- Status outputs (busy, echo count) are sized for the 16-bit segment display.

Parameters:
- DIST_W, 12, width of distance setting (matches measurer D width).
- TICK_DIV, 1, sys_clk cycles per distance tick; 1 = every cycle; must be >= 1.
- ECHO_LEN, 1, ticks S is held high per echo; must be >= 1.
- CNT_W, 16, width of echo counter.

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- dist_set  input  DIST_W  target distance in ticks; 0 = no target (out of range).
- L  input  1  laser strobe from measurer; synchronous to sys_clk.
- S  output  1  reflected-pulse sensor signal to measurer; registered.
- busy  output  1  high from accepted L rise until return to IDLE.
- echo_cnt  output  CNT_W  number of echoes emitted since reset; wraps at 2^CNT_W.
- miss  output  1  one-cycle pulse when an L rise is accepted with dist_set = 0.

Behaviour:
- Reset (async assert, sync release): S=0, busy=0, miss=0, echo_cnt=0, state IDLE, prescaler=0, delay counter=0, L_d=0.
- Edge detect: L_d registered; rise = L & ~L_d; only a rise is an event, level is ignored.
- Prescaler: free-running 0..TICK_DIV-1; tick when counter = TICK_DIV-1; always tick when TICK_DIV=1. The prescaler is cleared on an accepted rise, so delay phase is relative to the rise.
- States:
  - IDLE: rise and dist_set != 0 → latch d = dist_set; load delay counter = 2*d (width DIST_W+1, no overflow); busy=1; go WAIT. Rise and dist_set = 0 → miss=1 for one cycle; stay IDLE.
  - WAIT: decrement on tick. When the count reaches 1 and a tick occurs → go ECHO. S=1 is registered in the same edge.
  - ECHO: S=1; length counter runs ECHO_LEN ticks, then S=0 and echo_cnt+1 (same edge) → go HOLDOFF.
  - HOLDOFF: waits until L=0 (already low → one cycle), then IDLE with busy=0.
- Timing at TICK_DIV=1: L first high in cycle k → S first high in cycle k+2d, high for exactly ECHO_LEN cycles. The measurer therefore reads D = d.
- L rises during WAIT/ECHO/HOLDOFF are ignored: no restart, no miss. dist_set changes after latch have no effect on the echo in flight.
- Simultaneous: L rise in the same cycle HOLDOFF exits → ignored (IDLE sees the event only from the next rise).
- echo_cnt wraps from all-ones to 0 silently.
- Reset asserted mid-echo: S drops to 0 immediately (async), no count increment.

Optional Feature:
- Macro ECHO_JITTER_EN.
- Defined: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset) advances every cycle. On each accepted rise, bits [1:0] select a delay offset of -1, 0, 0, +1 ticks applied to 2*d. An offset of -1 when 2*d = 2 clamps to 2. Models range noise.
- Undefined: no LFSR; delay exactly 2*d; all timing above is exact.

Test Plan:
- dist_set=5, TICK_DIV=1, ECHO_LEN=1, one-cycle L pulse at cycle 10 → S high only in cycle 20; echo_cnt=1; busy high from cycle 11 through HOLDOFF exit.
- dist_set=0, L pulse → miss high one cycle, S stays 0, echo_cnt unchanged, busy stays 0.
- dist_set=3, L held high for 20 cycles → single S pulse at k+6; no second echo until L falls and rises again; second rise gives a second echo, echo_cnt=2.
- dist_set=4, second L rise at k+3 and dist_set changed to 9 → ignored; S at k+8 only.
- TICK_DIV=4, ECHO_LEN=2, dist_set=2 → S rises 16 cycles after L rise, high for 8 cycles.
- Reset low while S=1 → S=0 asynchronously, echo_cnt=0; after release, L pulse with dist_set=1 → S at k+2.
